// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and instruction field layout.
// Imported by the fetch unit, its field splitter and decode-side monitors.
package cpu_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_HALT
    } fetch_state_e;

    localparam int OP_HI   = 31;
    localparam int OP_LO   = 26;
    localparam int RS_HI   = 25;
    localparam int RS_LO   = 21;
    localparam int RT_HI   = 20;
    localparam int RT_LO   = 16;
    localparam int RD_HI   = 15;
    localparam int RD_LO   = 11;
    localparam int FUNC_HI = 5;
    localparam int FUNC_LO = 0;
    localparam int IMM_HI  = 15;
    localparam int IMM_LO  = 0;

    localparam logic [5:0] HALT_OP_DEF = 6'h3F;
    localparam int         PC_STEP_DEF = 4;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus.
// The fetch unit is the master, the memory is the slave.
interface instr_fetch_unit_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit_field_split.sv
// Combinational split of a 32-bit instruction word into decode fields.
// Shared by the fetch unit and the decode-side debug monitor.
module instr_field_split
    import cpu_pkg::*;
(
    input  logic [31:0] ir,
    output logic [5:0]  op_code,
    output logic [5:0]  func_code,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm
);

    assign op_code   = ir[OP_HI:OP_LO];
    assign func_code = ir[FUNC_HI:FUNC_LO];
    assign rs        = ir[RS_HI:RS_LO];
    assign rt        = ir[RT_HI:RT_LO];
    assign rd        = ir[RD_HI:RD_LO];
    assign imm       = ir[IMM_HI:IMM_LO];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, instruction-memory handshake, instruction register,
// retire counting and HALT detection.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter int              INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = PC_STEP_DEF,
    parameter logic [5:0]      HALT_OP  = HALT_OP_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    instr_fetch_unit_if.master imem,
    input  logic              pc_we,
    input  logic              mem_done,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              instr_valid,
    output logic [5:0]        op_code,
    output logic [5:0]        func_code,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [15:0]       imm,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [31:0]       retire_count
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               halted_q, halted_d;
    logic [31:0]        retire_q, retire_d;
    logic               advance;
    logic [ADDR_W-1:0]  seq_pc;
    logic [ADDR_W-1:0]  br_pc;

    assign advance = pc_we | mem_done;
    assign seq_pc  = pc_q + ADDR_W'(PC_STEP);
    assign br_pc   = {branch_target[ADDR_W-1:2], 2'b00};

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        halted_d = halted_q;
        retire_d = retire_q;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem.imem_ack) begin
                    ir_d    = imem.imem_rdata;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (advance) begin
                    retire_d = retire_q + 32'd1;
                    if (op_code == HALT_OP) begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end else begin
                        pc_d    = branch_taken ? br_pc : seq_pc;
                        state_d = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
        endcase
    end

    // Async clear drops imem_req mid-handshake; memory drops the request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            halted_q <= 1'b0;
            retire_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            halted_q <= halted_d;
            retire_q <= retire_d;
        end
    end

    instr_field_split u_split (
        .ir        (ir_q[31:0]),
        .op_code   (op_code),
        .func_code (func_code),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .imm       (imm)
    );

    assign imem.imem_req  = (state_q == S_FETCH);
    assign imem.imem_addr = pc_q;
    assign instr_valid    = (state_q == S_HOLD);
    assign pc             = pc_q;
    assign halted         = halted_q;
    assign retire_count   = retire_q;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the control unit.
- Holds the program counter and runs a request/acknowledge handshake to instruction memory.
- Latches each returned word into an instruction register and presents op_code/func_code and operand fields to decode.
- Advances the PC (sequential or branch) when the downstream control/execute path signals completion; stops on a HALT opcode.

Parameters:
- ADDR_W, 32, PC / instruction-memory address width.
- INSTR_W, 32, instruction width. Fields are fixed at 32-bit positions.
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment in bytes.
- HALT_OP, 6'h3F, op_code that halts fetch.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  ADDR_W  fetch address; equals pc
- imem_ack  in  1  memory has imem_rdata valid this cycle
- imem_rdata  in  INSTR_W  fetched instruction word
- pc_we  in  1  control unit PC write enable (instruction complete, no memory op)
- mem_done  in  1  data-memory access complete (completes a load/store instruction)
- branch_taken  in  1  Branch qualified by ALU condition, sampled on advance
- branch_target  in  ADDR_W  next PC when branch_taken
- instr_valid  out  1  instruction register holds a valid, unretired instruction
- op_code  out  6  ir[31:26]
- func_code  out  6  ir[5:0]
- rs  out  5  ir[25:21]
- rt  out  5  ir[20:16]
- rd  out  5  ir[15:11]
- imm  out  16  ir[15:0]
- pc  out  ADDR_W  address of the current instruction
- halted  out  1  HALT retired; fetch stopped
- retire_count  out  32  number of instructions retired

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. All state registers are cleared immediately on assertion, including mid-handshake.
- Reset values:
  - pc = RESET_PC, ir = 0, so all field outputs = 0.
  - imem_req = 0, instr_valid = 0, halted = 0, retire_count = 0.
  - state = S_IDLE.
- State machine:
  - S_IDLE: outputs idle. Always goes to S_FETCH on the next edge after reset release.
  - S_FETCH: imem_req = 1. imem_addr = pc, held stable while waiting. On imem_ack: ir <= imem_rdata, go to S_HOLD. Without ack: stay, keep req high. No timeout.
  - S_HOLD: instr_valid = 1 and ir is stable. Advance = pc_we | mem_done.
    - On advance, with op_code == HALT_OP: go to S_HALT, halted <= 1, pc unchanged.
    - On advance otherwise: pc <= branch_taken ? {branch_target[ADDR_W-1:2], 2'b00} : pc + PC_STEP. Go to S_FETCH.
    - On advance in either case, retire_count increments.
  - S_HALT: instr_valid = 0, imem_req = 0. Exit only via reset.
- Latency:
  - imem_ack in cycle N gives instr_valid = 1 in cycle N+1.
  - Advance in cycle M gives imem_req = 1 with the new pc in cycle M+1.
  - Minimum 2 cycles per instruction with zero-wait memory.
- Arithmetic:
  - pc + PC_STEP wraps modulo 2^ADDR_W.
  - Branch target low two bits are forced to 0.
  - retire_count wraps at 2^32.
- Boundary conditions:
  - pc_we and mem_done high in the same cycle: a single advance, counted once.
  - pc_we, mem_done, branch_taken and imem_ack are ignored outside their consuming state. This includes a stray ack in S_HOLD or S_IDLE.
  - branch_taken is ignored unless advance is high.
  - Reset asserted while imem_req is high: req drops combinationally with state. Memory must tolerate the abandoned request.
- All outputs are decoded from registered state. No combinational path from imem_ack to instr_valid.

Decomposition:
- Shared package cpu_pkg holds:
  - fetch state enum (S_IDLE, S_FETCH, S_HOLD, S_HALT);
  - instruction field bit-position constants (OP_HI/LO, RS_HI/LO, RT_HI/LO, RD_HI/LO, FUNC_HI/LO, IMM_HI/LO);
  - HALT_OP and PC_STEP defaults.
- One natural sub-module: instr_field_split. It is purely combinational: ir to op_code/func_code/rs/rt/rd/imm, and it is reused by the decode-side debug monitor.
- The FSM, PC and counter stay in the top module.

Test Plan:
- Reset release, memory acks the cycle after req with rdata 0x012A4020 → imem_addr = 0x0, instr_valid on the next cycle, op_code = 0x00, func_code = 0x20, rs = 9, rt = 10, rd = 8.
- Sequential run with pc_we pulsed once per instruction over three instructions → addresses 0x0, 0x4, 0x8 fetched in order; retire_count = 3; 2 cycles per instruction.
- Load instruction: pc_we = 0 for 5 cycles, then mem_done = 1 → instr_valid held 5 cycles with ir stable, no new req; then pc = 0x4.
- Branch: advance with branch_taken = 1 and branch_target = 0x103 → next imem_addr = 0x100. Same with branch_taken = 0 → next imem_addr = pc + 4.
- Ack delayed 4 cycles with a stray ack in S_HOLD → req and addr stable throughout the wait; stray ack ignored (ir unchanged); pc wrap from 0xFFFFFFFC to 0x0 verified.
- HALT (rdata 0xFC000000) retired → halted = 1, imem_req stays 0 for 20 cycles. rst_n pulsed mid-fetch → all outputs return to reset values immediately, and fetch restarts at RESET_PC.
